decoder_scan_onehot: RTL and testbench
======================================

// Module: decoder_scan_onehot
// PURPOSE
//  Parametrised N-to-2^N one-hot decoder with registered output and an auto-scan mode.
//  Direct mode: decodes a validated select word, e.g. for chip/row select.
//  Scan mode: steps through indices 0..last with a programmable dwell, e.g. for display digit strobing.
//  Sits between control logic and select lines. Single clock domain.
// PARAMETERS
//  SEL_W       3   select width; OUT_W = 2**SEL_W (localparam, not overridable)
//  DIV_W       8   dwell prescaler width
//  ACTIVE_LOW  0   1 = out lines active-low (inactive = all ones)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      block enable; 0 forces IDLE
//  mode       in   1      0 = direct, 1 = scan
//  sel_valid  in   1      direct-mode strobe; sel captured when high
//  sel        in   SEL_W  direct-mode select index
//  div        in   DIV_W  scan dwell: each index held div+1 cycles
//  last       in   SEL_W  scan upper bound (inclusive)
//  out        out  OUT_W  one-hot select lines (polarity per ACTIVE_LOW)
//  idx        out  SEL_W  index currently decoded on out
//  tick       out  1      1-cycle pulse on every scan advance
//  wrap       out  1      1-cycle pulse when scan wraps to 0
// BEHAVIOUR
//  Clock/reset: one clock (clk); rst_n is asynchronous, active-low.
//  Reset (async assert, sync release): state=IDLE, idx=0, prescaler=0, tick=0, wrap=0,
//    out=inactive (all 0, or all 1 if ACTIVE_LOW).
//  Register timing: all outputs registered.
//    - out, idx and state update on the same edge, so out always decodes idx.
//    - out is inactive whenever state=IDLE.
//  FSM states: IDLE, DIRECT, SCAN.
//  Transitions (evaluated every edge, en has priority):
//    - en=0 -> IDLE. idx holds; out goes inactive on that edge; tick/wrap forced 0.
//    - IDLE and en=1 -> DIRECT if mode=0; -> SCAN if mode=1.
//      Entering SCAN from IDLE clears idx and prescaler to 0.
//    - DIRECT and mode=1 -> SCAN: idx=0, prescaler=0.
//    - SCAN and mode=0 -> DIRECT: idx and out hold until the next sel_valid.
//  DIRECT mode:
//    - sel_valid=1 -> idx<=sel, out<=onehot(sel). Latency: 1 cycle from strobe edge.
//    - sel_valid=0 -> hold. tick and wrap stay 0.
//    - sel_valid in the IDLE->DIRECT entry cycle is captured.
//  SCAN mode:
//    - prescaler counts 0..div.
//    - When prescaler==div: prescaler<=0 and tick<=1.
//      If idx>=last: idx<=0, wrap<=1. Otherwise: idx<=idx+1.
//    - div=0 -> advance every cycle. last=0 -> idx stays 0; tick and wrap pulse each advance.
//    - last reduced below current idx -> the next advance wraps to 0, with wrap.
//    - div changed mid-dwell -> takes effect on the compare immediately;
//      if prescaler>div, it runs on and wraps through max(DIV_W).
//    - sel and sel_valid are ignored.
//  Arithmetic: idx increment is SEL_W wide; it never exceeds last in scan.
//    Prescaler is DIV_W wide, unsigned.
//  Reset mid-operation: immediate return to reset values; no partial pulse on tick/wrap.
// TESTING (SEL_W=3, DIV_W=8 unless noted)
//  1. Assert rst_n=0 mid-scan, between clock edges -> out=8'h00, idx=0, tick=0, wrap=0 immediately.
//  2. en=1, mode=0, sel=5 with 1-cycle sel_valid -> next edge out=8'h20, idx=5; held 10 cycles
//     with sel_valid=0 while sel toggles.
//  3. mode=1, div=2, last=3 -> idx 0,1,2,3,0 each held 3 cycles, out 01,02,04,08,01;
//     tick every 3rd cycle; wrap only on 3->0.
//  4. div=0, last=0 in scan -> idx=0 and out=8'h01 constant; tick=wrap=1 every cycle.
//  5. Scan last=7; at idx=5 set last=2 -> next advance gives idx=0 with wrap=1,
//     then sequence 0,1,2,0.
//  6. ACTIVE_LOW=1: en=0 -> out=8'hFF. Then en=1, mode=0, sel=0 strobe -> out=8'hFE.
//     Drop en mid-scan -> out=8'hFF next edge; re-enable in scan -> idx restarts at 0.

Source files
------------

// File: rtl/decoder_scan_onehot.sv
// decoder_scan_onehot: N-to-2^N one-hot decoder with registered direct-select and auto-scan modes
module decoder_scan_onehot #(
  parameter int SEL_W      = 3,
  parameter int DIV_W      = 8,
  parameter bit ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DIV_W-1:0]      div,
  input  logic [SEL_W-1:0]      last,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      idx,
  output logic                  tick,
  output logic                  wrap
);
  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] inact = {OUT_W{ACTIVE_LOW}};
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state;
  logic [DIV_W-1:0] presc;
  function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] i);
    return ({{(OUT_W-1){1'b0}}, 1'b1} << i) ^ inact;
  endfunction
  // out is always loaded together with idx so it can never disagree with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      presc <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      out   <= inact;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (!en) begin
        state <= IDLE;
        out   <= inact;
      end else if (mode) begin
        if (state != SCAN) begin
          state <= SCAN;
          idx   <= '0;
          presc <= '0;
          out   <= dec('0);
        end else if (presc == div) begin
          presc <= '0;
          tick  <= 1'b1;
          wrap  <= idx >= last;
          idx   <= idx >= last ? '0 : idx + 1'b1;
          out   <= dec(idx >= last ? '0 : idx + 1'b1);
        end else begin
          presc <= presc + 1'b1;
        end
      end else begin
        state <= DIRECT;
        idx   <= sel_valid ? sel : idx;
        out   <= dec(sel_valid ? sel : idx);
      end
    end
  end
endmodule

// File: tb/tb_decoder_scan_onehot.sv
// tb_decoder_scan_onehot: scoreboard bench driving both output polarities with shared stimulus
module tb_decoder_scan_onehot;
  logic clk = 0, rst_n = 1, en = 0, mode = 0, sel_valid = 0;
  logic [2:0] sel = 0, last = 0;
  logic [7:0] div = 0;
  logic [7:0] out0, out1;
  logic [2:0] idx0, idx1;
  logic tick0, tick1, wrap0, wrap1;
  int errors = 0, checks = 0;
  typedef struct {logic [7:0] out; logic [2:0] idx; logic tick; logic wrap;} exp_t;
  exp_t q[$];
  int st = 0, m_idx = 0, cnt = 0;
  bit m_tick = 0, m_wrap = 0;

  always #5 clk = ~clk;

  decoder_scan_onehot #(.SEL_W(3), .DIV_W(8), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
    .div(div), .last(last), .out(out0), .idx(idx0), .tick(tick0), .wrap(wrap0));
  decoder_scan_onehot #(.SEL_W(3), .DIV_W(8), .ACTIVE_LOW(1)) u_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
    .div(div), .last(last), .out(out1), .idx(idx1), .tick(tick1), .wrap(wrap1));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // reference: st 0=idle 1=direct 2=scan; cnt counts cycles spent on the current scan index
  task automatic model();
    m_tick = 0;
    m_wrap = 0;
    if (!en) st = 0;
    else if (mode) begin
      if (st != 2) begin
        st = 2; m_idx = 0; cnt = 0;
      end else if (cnt == int'(div)) begin
        cnt = 0; m_tick = 1;
        if (m_idx >= int'(last)) begin m_idx = 0; m_wrap = 1; end
        else m_idx = m_idx + 1;
      end else cnt = (cnt + 1) % 256;
    end else begin
      st = 1;
      if (sel_valid) m_idx = int'(sel);
    end
  endtask

  task automatic model_reset();
    st = 0; m_idx = 0; cnt = 0;
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      @(posedge clk);
      model();
      e.out  = st == 0 ? 8'h00 : 8'(1 << m_idx);
      e.idx  = 3'(m_idx);
      e.tick = m_tick;
      e.wrap = m_wrap;
      q.push_back(e);
      #1;
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_out"}, out0, 8'h00);
    chk({name, "_out_al"}, out1, 8'hFF);
    chk({name, "_idx"}, {5'd0, idx0}, 8'd0);
    chk({name, "_tick"}, {7'd0, tick0}, 8'd0);
    chk({name, "_wrap"}, {7'd0, wrap0}, 8'd0);
    chk({name, "_idx_al"}, {5'd0, idx1}, 8'd0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("out", out0, e.out);
      chk("out_al", out1, ~e.out);
      chk("idx", {5'd0, idx0}, {5'd0, e.idx});
      chk("idx_al", {5'd0, idx1}, {5'd0, e.idx});
      chk("tick", {6'd0, tick1, tick0}, {6'd0, e.tick, e.tick});
      chk("wrap", {6'd0, wrap1, wrap0}, {6'd0, e.wrap, e.wrap});
    end
  end

  initial begin
    #1 rst_n = 0;
    #2 check_reset("reset");
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    step(2);
    en = 1; mode = 0; sel = 5; sel_valid = 1;
    step();
    sel_valid = 0;
    for (int k = 0; k < 10; k++) begin sel = 3'($urandom); step(); end
    mode = 1; div = 2; last = 3;
    step(16);
    div = 0; last = 0;
    step(6);
    last = 7;
    for (int k = 0; k < 100 && m_idx != 5; k++) step();
    chk("reach_idx5", 8'(m_idx), 8'd5);
    last = 2;
    step(8);
    en = 0;
    step(2);
    en = 1; mode = 0; sel = 0; sel_valid = 1;
    step();
    sel_valid = 0; mode = 1; div = 1; last = 6;
    step(7);
    en = 0;
    step();
    en = 1;
    step(4);
    div = 2; last = 3;
    step(7);
    @(negedge clk);
    #1 rst_n = 0;
    #1 check_reset("async_reset");
    q.delete();
    model_reset();
    #1 rst_n = 1;
    for (int k = 0; k < 3000; k++) begin
      en = $urandom_range(0, 15) != 0;
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      sel_valid = 1'($urandom);
      sel = 3'($urandom);
      if ($urandom_range(0, 7) == 0) div = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) last = 3'($urandom);
      step();
    end
    @(negedge clk);
    #1 chk("queue_drained", 8'(q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
